// File: rtl/pc_gen.sv
// Fetch program counter with priority next-PC selection and a circular
// return-address stack that predicts targets for ret instructions.
module pc_gen #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
  parameter int              RAS_DEPTH = 4,
  parameter int              INC       = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            PCsrc,
  input  logic [XLEN-1:0] ImmOp,
  input  logic            reg_jump,
  input  logic [XLEN-1:0] reg_addr,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            is_call,
  input  logic            is_ret,
  output logic [XLEN-1:0] PC_out,
  output logic [XLEN-1:0] incPC,
  output logic            ras_valid,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_mispredict
);

  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0] r_pc;
  logic [PW-1:0]   r_ptr;
  logic [CW-1:0]   r_count;
  logic [XLEN-1:0] r_ras [RAS_DEPTH];
  logic            r_mispredict;

  logic [XLEN-1:0] w_next_pc;
  logic [XLEN-1:0] w_branch_tgt;
  logic [XLEN-1:0] w_jalr_tgt;
  logic [PW-1:0]   w_top_idx;
  logic            w_accept;
  logic            w_wr_en;
  logic [PW-1:0]   w_wr_idx;
  logic [PW-1:0]   w_ptr_nxt;
  logic [CW-1:0]   w_count_nxt;
  logic            w_mis_nxt;

  // r_ptr names the next free slot, so the top of stack sits one below it.
  assign w_top_idx    = r_ptr - PW'(1);
  assign w_branch_tgt = r_pc + ImmOp;
  assign w_jalr_tgt   = reg_addr & ~XLEN'(1);
  assign w_accept     = ~stall & ~trap;

  assign PC_out         = r_pc;
  assign incPC          = r_pc + XLEN'(INC);
  assign ras_valid      = (r_count != CW'(0));
  assign ras_top        = ras_valid ? r_ras[w_top_idx] : XLEN'(0);
  assign ras_mispredict = r_mispredict;

  // Next-PC priority: trap, JALR, branch/JAL, stall hold, sequential.
  always_comb begin
    w_next_pc = incPC;
    if (trap) begin
      w_next_pc = trap_vec;
    end else if (PCsrc) begin
      if (reg_jump) begin
        w_next_pc = w_jalr_tgt;
      end else begin
        w_next_pc = w_branch_tgt;
      end
    end else if (stall) begin
      w_next_pc = r_pc;
    end else begin
      w_next_pc = incPC;
    end
  end

  // RAS push/pop/swap decode and mispredict detection.
  always_comb begin
    w_wr_en     = 1'b0;
    w_wr_idx    = r_ptr;
    w_ptr_nxt   = r_ptr;
    w_count_nxt = r_count;
    w_mis_nxt   = 1'b0;
    if (trap) begin
      w_ptr_nxt   = PW'(0);
      w_count_nxt = CW'(0);
    end else if (w_accept) begin
      w_mis_nxt = is_ret & PCsrc & reg_jump & ras_valid & (w_jalr_tgt != ras_top);
      case ({is_call, is_ret})
        2'b10: begin
          w_wr_en   = 1'b1;
          w_wr_idx  = r_ptr;
          w_ptr_nxt = r_ptr + PW'(1);
          if (r_count == CW'(RAS_DEPTH)) begin
            w_count_nxt = r_count;
          end else begin
            w_count_nxt = r_count + CW'(1);
          end
        end
        2'b01: begin
          if (ras_valid) begin
            w_ptr_nxt   = w_top_idx;
            w_count_nxt = r_count - CW'(1);
          end else begin
            w_ptr_nxt   = r_ptr;
            w_count_nxt = r_count;
          end
        end
        2'b11: begin
          // Coroutine swap: replace the top in place; on empty stack it is a push.
          w_wr_en = 1'b1;
          if (ras_valid) begin
            w_wr_idx = w_top_idx;
          end else begin
            w_wr_idx    = r_ptr;
            w_ptr_nxt   = r_ptr + PW'(1);
            w_count_nxt = r_count + CW'(1);
          end
        end
        default: begin
          w_wr_en = 1'b0;
        end
      endcase
    end else begin
      w_wr_en = 1'b0;
    end
  end

  // PC, RAS bookkeeping and mispredict pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc         <= RESET_VEC;
      r_ptr        <= PW'(0);
      r_count      <= CW'(0);
      r_mispredict <= 1'b0;
    end else begin
      r_pc         <= w_next_pc;
      r_ptr        <= w_ptr_nxt;
      r_count      <= w_count_nxt;
      r_mispredict <= w_mis_nxt;
    end
  end

  // RAS entry storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        r_ras[i] <= XLEN'(0);
      end
    end else if (w_wr_en) begin
      r_ras[w_wr_idx] <= incPC;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed scoreboard bench for pc_gen: expectations are queued with each
// stimulus step and checked against the DUT just after the following edge.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, PCsrc, reg_jump, trap, is_call, is_ret;
  logic [31:0] ImmOp, reg_addr, trap_vec;
  logic [31:0] PC_out, incPC, ras_top;
  logic        ras_valid, ras_mispredict;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        valid;
    logic [31:0] top;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  pc_gen #(.XLEN(32), .RESET_VEC(32'h0000_0000), .RAS_DEPTH(4), .INC(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .PCsrc(PCsrc), .ImmOp(ImmOp),
    .reg_jump(reg_jump), .reg_addr(reg_addr), .trap(trap), .trap_vec(trap_vec),
    .is_call(is_call), .is_ret(is_ret), .PC_out(PC_out), .incPC(incPC),
    .ras_valid(ras_valid), .ras_top(ras_top), .ras_mispredict(ras_mispredict)
  );

  always #5 clk = ~clk;

  task automatic clr();
    stall = 1'b0; PCsrc = 1'b0; reg_jump = 1'b0; trap = 1'b0;
    is_call = 1'b0; is_ret = 1'b0;
    ImmOp = 32'h0; reg_addr = 32'h0; trap_vec = 32'h0;
  endtask

  task automatic push_exp(input string tag, input logic [31:0] pc,
                          input logic valid, input logic [31:0] top, input logic mis);
    exp_t e;
    e.tag = tag; e.pc = pc; e.valid = valid; e.top = top; e.mis = mis;
    exp_q.push_back(e);
  endtask

  task automatic compare_front();
    exp_t e;
    logic [31:0] exp_inc;
    e = exp_q.pop_front();
    exp_inc = e.pc + 32'd4;
    n_tests++;
    assert (PC_out === e.pc) else begin
      n_fail++; $error("FAIL %s PC_out got %h expected %h", e.tag, PC_out, e.pc);
    end
    n_tests++;
    assert (incPC === exp_inc) else begin
      n_fail++; $error("FAIL %s incPC got %h expected %h", e.tag, incPC, exp_inc);
    end
    n_tests++;
    assert (ras_valid === e.valid) else begin
      n_fail++; $error("FAIL %s ras_valid got %b expected %b", e.tag, ras_valid, e.valid);
    end
    n_tests++;
    assert (ras_top === e.top) else begin
      n_fail++; $error("FAIL %s ras_top got %h expected %h", e.tag, ras_top, e.top);
    end
    n_tests++;
    assert (ras_mispredict === e.mis) else begin
      n_fail++; $error("FAIL %s ras_mispredict got %b expected %b", e.tag, ras_mispredict, e.mis);
    end
  endtask

  // Queue the expectation, let one edge pass, then check and clear inputs.
  task automatic cyc(input string tag, input logic [31:0] pc,
                     input logic valid, input logic [31:0] top, input logic mis);
    push_exp(tag, pc, valid, top, mis);
    @(posedge clk);
    #1;
    compare_front();
    clr();
  endtask

  task automatic now(input string tag, input logic [31:0] pc,
                     input logic valid, input logic [31:0] top, input logic mis);
    push_exp(tag, pc, valid, top, mis);
    compare_front();
  endtask

  initial begin
    rst = 1'b0;
    clr();
    #1 now("reset", 32'h0, 1'b0, 32'h0, 1'b0);
    #11 rst = 1'b1;
    cyc("seq1", 32'h4, 1'b0, 32'h0, 1'b0);
    cyc("seq2", 32'h8, 1'b0, 32'h0, 1'b0);
    cyc("seq3", 32'hC, 1'b0, 32'h0, 1'b0);
    cyc("seq4", 32'h10, 1'b0, 32'h0, 1'b0);

    PCsrc = 1'b1; ImmOp = 32'hFFFF_FFF8;
    cyc("branch_neg", 32'h8, 1'b0, 32'h0, 1'b0);
    PCsrc = 1'b1; reg_jump = 1'b1; reg_addr = 32'h101;
    cyc("jalr_bit0", 32'h100, 1'b0, 32'h0, 1'b0);
    stall = 1'b1; PCsrc = 1'b1; ImmOp = 32'hFFFF_FFF8;
    cyc("stall_branch", 32'hF8, 1'b0, 32'h0, 1'b0);
    stall = 1'b1; PCsrc = 1'b1; reg_jump = 1'b1; reg_addr = 32'h101;
    cyc("stall_jalr", 32'h100, 1'b0, 32'h0, 1'b0);
    stall = 1'b1;
    cyc("stall_hold", 32'h100, 1'b0, 32'h0, 1'b0);
    is_call = 1'b1;
    cyc("call_seq", 32'h104, 1'b1, 32'h104, 1'b0);
    stall = 1'b1; is_call = 1'b1;
    cyc("stall_call", 32'h104, 1'b1, 32'h104, 1'b0);
    trap = 1'b1; trap_vec = 32'h8000_0000; PCsrc = 1'b1; stall = 1'b1; ImmOp = 32'h40;
    cyc("trap", 32'h8000_0000, 1'b0, 32'h0, 1'b0);

    PCsrc = 1'b1; reg_jump = 1'b1; reg_addr = 32'hFFFF_FFFC;
    cyc("to_top", 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0);
    cyc("wrap", 32'h0, 1'b0, 32'h0, 1'b0);

    for (int i = 0; i < 5; i++) begin
      is_call = 1'b1; PCsrc = 1'b1; reg_jump = 1'b1; reg_addr = 32'(i + 1) * 32'h100;
      cyc("call5", 32'(i + 1) * 32'h100, 1'b1, 32'(i) * 32'h100 + 32'h4, 1'b0);
    end
    for (int i = 4; i >= 1; i--) begin
      is_ret = 1'b1; PCsrc = 1'b1; reg_jump = 1'b1; reg_addr = 32'(i) * 32'h100 + 32'h4;
      cyc("pop4", 32'(i) * 32'h100 + 32'h4, (i > 1),
          (i > 1) ? 32'(i - 1) * 32'h100 + 32'h4 : 32'h0, 1'b0);
    end
    is_ret = 1'b1; PCsrc = 1'b1; reg_jump = 1'b1; reg_addr = 32'h200;
    cyc("pop_empty", 32'h200, 1'b0, 32'h0, 1'b0);
    is_call = 1'b1;
    cyc("call_after_empty", 32'h204, 1'b1, 32'h204, 1'b0);
    is_ret = 1'b1; PCsrc = 1'b1; reg_jump = 1'b1; reg_addr = 32'h204;
    cyc("pop_one", 32'h204, 1'b0, 32'h0, 1'b0);

    PCsrc = 1'b1; reg_jump = 1'b1; reg_addr = 32'h20;
    cyc("to_20", 32'h20, 1'b0, 32'h0, 1'b0);
    is_call = 1'b1;
    cyc("call_20", 32'h24, 1'b1, 32'h24, 1'b0);
    is_ret = 1'b1; PCsrc = 1'b1; reg_jump = 1'b1; reg_addr = 32'h24;
    cyc("ret_ok", 32'h24, 1'b0, 32'h0, 1'b0);
    PCsrc = 1'b1; reg_jump = 1'b1; reg_addr = 32'h20;
    cyc("to_20b", 32'h20, 1'b0, 32'h0, 1'b0);
    is_call = 1'b1;
    cyc("call_20b", 32'h24, 1'b1, 32'h24, 1'b0);
    is_ret = 1'b1; PCsrc = 1'b1; reg_jump = 1'b1; reg_addr = 32'h28;
    cyc("ret_bad", 32'h28, 1'b0, 32'h0, 1'b1);
    cyc("mis_clear", 32'h2C, 1'b0, 32'h0, 1'b0);

    is_call = 1'b1;
    cyc("swap_push1", 32'h30, 1'b1, 32'h30, 1'b0);
    is_call = 1'b1;
    cyc("swap_push2", 32'h34, 1'b1, 32'h34, 1'b0);
    is_call = 1'b1; is_ret = 1'b1; PCsrc = 1'b1; reg_jump = 1'b1; reg_addr = 32'h34;
    cyc("swap", 32'h34, 1'b1, 32'h38, 1'b0);
    is_ret = 1'b1; PCsrc = 1'b1; reg_jump = 1'b1; reg_addr = 32'h38;
    cyc("swap_pop1", 32'h38, 1'b1, 32'h30, 1'b0);
    is_ret = 1'b1; PCsrc = 1'b1; reg_jump = 1'b1; reg_addr = 32'h30;
    cyc("swap_pop2", 32'h30, 1'b0, 32'h0, 1'b0);

    is_call = 1'b1;
    cyc("pre_rst1", 32'h34, 1'b1, 32'h34, 1'b0);
    is_call = 1'b1; PCsrc = 1'b1; reg_jump = 1'b1; reg_addr = 32'h40;
    cyc("pre_rst2", 32'h40, 1'b1, 32'h38, 1'b0);
    #2 rst = 1'b0;
    #1 now("async_rst", 32'h0, 1'b0, 32'h0, 1'b0);
    #2 rst = 1'b1;
    cyc("post_rst", 32'h4, 1'b0, 32'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
